fifo_wr_arbiter: RTL

//  Shares the single write port of the synchronous FIFO between NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_rr.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Holds the arbiter FSM state type and the width functions for the
// grant index, credit counter and burst counter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a producer index.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Credit counter must represent 0..DEPTH inclusive.
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Burst counter counts 0..MAX_BURST-1, at least one bit.
    function automatic int burst_w(input int mb);
        return (mb <= 2) ? 1 : $clog2(mb);
    endfunction

    localparam int CRED_W  = cred_w(16);
    localparam int BURST_W = burst_w(4);

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: searches upward from i_ptr+1 (wrapping)
// and returns the first requesting index.
// Ports:
//   i_req    : request vector, one bit per producer
//   i_ptr    : index of the last grantee
//   o_winner : chosen producer index (0 when o_any is low)
//   o_any    : at least one request is set
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [IW-1:0]      o_winner,
    output logic               o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest
    // requester after the pointer is the last one written.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            w_idx = w_sum[IW-1:0];
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one synchronous-FIFO write port among NUM_REQ valid/ready
// producers with round-robin bursts and a local credit counter.
// Ports:
//   clk, rst      : clock; synchronous active-low reset
//   req_valid/data: producer words, slice i = [i*DWIDTH +: DWIDTH]
//   req_ready     : combinational, one-hot or zero
//   fifo_wr_en/wdata : registered FIFO write
//   fifo_rd_en/empty/full : observed FIFO read side and full flag
//   grant_id      : current/last grantee
//   credits       : free FIFO slots as seen by the arbiter
//   err           : sticky protocol error
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4,
    localparam int IW = idx_w(NUM_REQ),
    localparam int CW = cred_w(DEPTH),
    localparam int BW = burst_w(MAX_BURST)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DWIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DWIDTH-1:0]         fifo_wdata,
    input  logic                      fifo_rd_en,
    input  logic                      fifo_empty,
    input  logic                      fifo_full,
    output logic [IW-1:0]             grant_id,
    output logic [CW-1:0]             credits,
    output logic                      err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     w_rr_ptr_nxt;
    logic [IW-1:0]     r_grant_id;
    logic [IW-1:0]     w_grant_id_nxt;
    logic [BW-1:0]     r_burst_cnt;
    logic [BW-1:0]     w_burst_cnt_nxt;
    logic [CW-1:0]     r_credits;
    logic [CW-1:0]     w_credits_nxt;
    logic              r_wr_en;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_err;

    logic [IW-1:0]     w_winner;
    logic              w_any;
    logic              w_gnt_valid;
    logic [DWIDTH-1:0] w_gnt_data;
    logic              w_cred_ok;
    logic              w_accept;
    logic              w_pop;
    logic              w_overrun;
    logic              w_last_beat;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_gnt_valid = req_valid[r_grant_id];
    assign w_gnt_data  = req_data[r_grant_id*DWIDTH +: DWIDTH];
    assign w_cred_ok   = (r_credits != '0);
    assign w_accept    = (r_state == GRANT) && w_gnt_valid && w_cred_ok;
    assign w_pop       = fifo_rd_en && !fifo_empty;
    // A pop with nothing outstanding means the read side and the
    // credit mirror disagree; the counter saturates instead of wrapping.
    assign w_overrun   = w_pop && !w_accept
                      && (r_credits == CW'(DEPTH));
    assign w_last_beat = (r_burst_cnt == BW'(MAX_BURST-1));

    always_comb begin
        req_ready = '0;
        if (r_state == GRANT && w_cred_ok) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_burst_cnt_nxt = r_burst_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt     = GRANT;
                    w_grant_id_nxt  = w_winner;
                    w_burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_gnt_valid || (w_accept && w_last_beat)) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = r_grant_id;
                end else if (w_accept) begin
                    w_burst_cnt_nxt = r_burst_cnt + BW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_accept, w_pop})
            2'b10: w_credits_nxt = r_credits - CW'(1);
            2'b01: begin
                if (!w_overrun) begin
                    w_credits_nxt = r_credits + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr    <= IW'(NUM_REQ-1);
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_credits   <= CW'(DEPTH);
            r_wr_en     <= 1'b0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_credits   <= w_credits_nxt;
            r_wr_en     <= w_accept;
            if (w_accept) begin
                r_wdata <= w_gnt_data;
            end
            r_err <= r_err | (r_wr_en & fifo_full) | w_overrun;
        end
    end

    assign fifo_wr_en = r_wr_en;
    assign fifo_wdata = r_wdata;
    assign grant_id   = r_grant_id;
    assign credits    = r_credits;
    assign err        = r_err;

endmodule
